// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// dmem_pkg: size encodings, FSM states and byte-lane helpers (rev 1.0)
// ============================================================================
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Size 3 is illegal and always reported as an error.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lo[0];
      SZ_WORD: misaligned = (lo != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: byte_enable = 4'b0001 << lo;
      SZ_HALF: byte_enable = lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: byte_enable = 4'b1111;
      default: byte_enable = 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data so every candidate lane carries it.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: store_lanes = {4{wdata[7:0]}};
      SZ_HALF: store_lanes = {2{wdata[15:0]}};
      default: store_lanes = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lo,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: load_extract = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: load_extract = uns ? {16'h0, h} : {{16{h[15]}}, h};
      SZ_WORD: load_extract = word;
      default: load_extract = 32'h0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// dmem_array: single-port synchronous RAM, byte-write enables, registered read (rev 1.0)
// ============================================================================
module dmem_array #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    en_i,
  input  logic [DATA_WIDTH/8-1:0] we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read-before-write; the read register only moves when the port is enabled.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (we_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder: load/store responder with fixed configurable latency (rev 1.0)
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [31:0]           req_addr_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  busy_o
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       we_q, uns_q, err_q;
  logic [1:0] size_q, lo_q;

  logic                    accept;
  logic                    req_err;
  logic [DATA_WIDTH/8-1:0] ram_be;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic [DATA_WIDTH-1:0]   ram_rdata;
  logic [31-ADDR_WIDTH-2:0] unused_addr_hi;

  // Upper address bits alias onto the array.
  assign unused_addr_hi = req_addr_i[31:ADDR_WIDTH+2];

  assign accept    = (state_q == IDLE) && req_valid_i && !reset_i;
  assign req_err   = misaligned(req_size_i, req_addr_i[1:0]);
  assign ram_be    = (req_we_i && !req_err) ? byte_enable(req_size_i, req_addr_i[1:0]) : '0;
  assign ram_wdata = store_lanes(req_size_i, req_wdata_i);

  // Stores commit and loads sample the array on the accept edge only, so the
  // read register holds the load word untouched until the response completes.
  dmem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (accept),
    .we_i    (ram_be),
    .addr_i  (req_addr_i[ADDR_WIDTH+1:2]),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'd0;
      lo_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q   <= req_we_i;
        uns_q  <= req_unsigned_i;
        err_q  <= req_err;
        size_q <= req_size_i;
        lo_q   <= req_addr_i[1:0];
      end
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_err_o   = rsp_valid_o && err_q;
  assign rsp_rdata_o = (rsp_valid_o && !we_q && !err_q)
                       ? load_extract(ram_rdata, size_q, lo_q, uns_q) : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder: directed + randomized bench against a byte-array model (rev 1.0)
// ============================================================================
module tb_dmem_responder;

  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_req_valid, a_req_ready, a_req_we, a_req_unsigned;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_err, a_busy;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [1:0]  a_req_size;
  logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [1:0]  b_req_size;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem_a [4096];
  logic [31:0] wmem_b [16];
  logic [31:0] q_exp [$];
  int          nacc;
  logic [31:0] exp_rd;
  logic        exp_er;
  int          lat;

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT_A), .DATA_WIDTH(32)) dut_a (
    .clk_i(clk), .reset_i(rst),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_we_i(a_req_we),
    .req_addr_i(a_req_addr), .req_size_i(a_req_size), .req_unsigned_i(a_req_unsigned),
    .req_wdata_i(a_req_wdata), .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
    .rsp_rdata_o(a_rsp_rdata), .rsp_err_o(a_rsp_err), .busy_o(a_busy)
  );

  dmem_responder #(.ADDR_WIDTH(4), .LATENCY(LAT_B), .DATA_WIDTH(32)) dut_b (
    .clk_i(clk), .reset_i(rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
    .req_addr_i(b_req_addr), .req_size_i(b_req_size), .req_unsigned_i(b_req_unsigned),
    .req_wdata_i(b_req_wdata), .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
    .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err), .busy_o(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory of 4096 bytes; misaligned/illegal requests do nothing.
  task automatic model_a(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic er);
    int base;
    int n;
    rd = 32'h0;
    er = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
    if (!er) begin
      base = int'(addr % 4096);
      n    = 1 << size;
      for (int i = 0; i < n; i++) begin
        if (we) mem_a[base + i] = wdata[8*i +: 8];
        else    rd[8*i +: 8]    = mem_a[base + i];
      end
      if (!we && !uns && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8 * n));
    end
  endtask

  task automatic txn_a(input string tag, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                       input int stall);
    logic [31:0] erd;
    logic        eer;
    int          l;
    model_a(we, addr, size, uns, wdata, erd, eer);
    chk({tag, ":ready_before"}, {31'h0, a_req_ready}, 32'h1);
    a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr;
    a_req_size = size; a_req_unsigned = uns; a_req_wdata = wdata;
    @(posedge clk); #1;
    a_req_valid = 1'b0; a_req_we = $urandom_range(0, 1); a_req_addr = $urandom();
    a_req_size = 2'($urandom_range(0, 3)); a_req_unsigned = $urandom_range(0, 1);
    a_req_wdata = $urandom();
    l = 1;
    while (!a_rsp_valid && l < 40) begin
      @(posedge clk); #1;
      l++;
    end
    chk({tag, ":latency"}, 32'(l), 32'(LAT_A));
    if (a_rsp_valid) begin
      for (int s = 0; s < stall; s++) begin
        chk({tag, ":stall_rdata"}, a_rsp_rdata, erd);
        chk({tag, ":stall_busy"}, {31'h0, a_busy}, 32'h1);
        chk({tag, ":stall_ready"}, {31'h0, a_req_ready}, 32'h0);
        @(posedge clk); #1;
        chk({tag, ":stall_valid"}, {31'h0, a_rsp_valid}, 32'h1);
      end
      chk({tag, ":rdata"}, a_rsp_rdata, erd);
      chk({tag, ":err"}, {31'h0, a_rsp_err}, {31'h0, eer});
      chk({tag, ":hs_ready"}, {31'h0, a_req_ready}, 32'h0);
      a_rsp_ready = 1'b1;
      @(posedge clk); #1;
      a_rsp_ready = 1'b0;
      chk({tag, ":after_valid"}, {31'h0, a_rsp_valid}, 32'h0);
      chk({tag, ":after_busy"}, {31'h0, a_busy}, 32'h0);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_size = 0; a_req_unsigned = 0;
    a_req_wdata = 0; a_rsp_ready = 0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_size = 0; b_req_unsigned = 0;
    b_req_wdata = 0; b_rsp_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, a_req_ready}, 32'h1);
    chk("rst_valid", {31'h0, a_rsp_valid}, 32'h0);
    chk("rst_rdata", a_rsp_rdata, 32'h0);
    chk("rst_err", {31'h0, a_rsp_err}, 32'h0);
    chk("rst_busy", {31'h0, a_busy}, 32'h0);
    chk("rst_b_ready", {31'h0, b_req_ready}, 32'h1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed accesses
    txn_a("sw10",  1, 32'h10, 2'd2, 0, 32'hDEAD_BEEF, 0);
    txn_a("sw14",  1, 32'h14, 2'd2, 0, 32'hDEAD_BEEF, 0);
    txn_a("lw10",  0, 32'h10, 2'd2, 0, 32'h0, 0);
    txn_a("sb15",  1, 32'h15, 2'd0, 0, 32'h5555_5580, 0);
    txn_a("lb15",  0, 32'h15, 2'd0, 0, 32'h0, 0);
    txn_a("lbu15", 0, 32'h15, 2'd0, 1, 32'h0, 0);
    txn_a("lw14",  0, 32'h14, 2'd2, 0, 32'h0, 0);
    txn_a("lh16",  0, 32'h16, 2'd1, 0, 32'h0, 0);
    txn_a("lhu16", 0, 32'h16, 2'd1, 1, 32'h0, 0);
    txn_a("lw12",  0, 32'h12, 2'd2, 0, 32'h0, 0);
    txn_a("sh11",  1, 32'h11, 2'd1, 0, 32'h0000_FFFF, 0);
    txn_a("sz3",   1, 32'h10, 2'd3, 0, 32'h1111_1111, 0);
    txn_a("lw14b", 0, 32'h14, 2'd2, 0, 32'h0, 0);
    txn_a("lw10b", 0, 32'h10, 2'd2, 0, 32'h0, 0);
    txn_a("lw14s", 0, 32'h14, 2'd2, 0, 32'h0, 3);
    txn_a("lw_alias", 0, 32'hABCD_F014, 2'd2, 0, 32'h0, 1);

    // Reset while WAIT: store already committed, response dropped
    a_req_valid = 1; a_req_we = 1; a_req_addr = 32'h20; a_req_size = 2'd2;
    a_req_unsigned = 0; a_req_wdata = 32'h1234_5678;
    model_a(1, 32'h20, 2'd2, 0, 32'h1234_5678, exp_rd, exp_er);
    @(posedge clk); #1;
    a_req_valid = 0;
    chk("rstwait_busy", {31'h0, a_busy}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstwait_ready", {31'h0, a_req_ready}, 32'h1);
    chk("rstwait_valid", {31'h0, a_rsp_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rstwait_novalid", {31'h0, a_rsp_valid}, 32'h0);
    end
    txn_a("lw20", 0, 32'h20, 2'd2, 0, 32'h0, 0);

    // Reset wins over a simultaneous request: the store must not land
    txn_a("sw30", 1, 32'h30, 2'd2, 0, 32'h0BAD_C0DE, 0);
    a_req_valid = 1; a_req_we = 1; a_req_addr = 32'h30; a_req_size = 2'd2;
    a_req_wdata = 32'hCAFE_F00D;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; a_req_valid = 0;
    chk("rstprio_ready", {31'h0, a_req_ready}, 32'h1);
    @(posedge clk); #1;
    chk("rstprio_busy", {31'h0, a_busy}, 32'h0);
    txn_a("lw30", 0, 32'h30, 2'd2, 0, 32'h0, 0);

    // Reset while RESP drops the pending response
    a_req_valid = 1; a_req_we = 0; a_req_addr = 32'h10; a_req_size = 2'd2;
    @(posedge clk); #1;
    a_req_valid = 0;
    lat = 1;
    while (!a_rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rstresp_latency", 32'(lat), 32'(LAT_A));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstresp_valid", {31'h0, a_rsp_valid}, 32'h0);
    chk("rstresp_rdata", a_rsp_rdata, 32'h0);
    chk("rstresp_ready", {31'h0, a_req_ready}, 32'h1);

    // Randomized traffic over a 64-byte window with aliased upper bits
    for (int w = 0; w < 16; w++)
      txn_a("rinit", 1, 32'h100 + 32'(4 * w), 2'd2, 0, $urandom(), 0);
    for (int r = 0; r < 60; r++)
      txn_a("rand", 1'($urandom_range(0, 1)),
            ($urandom() & 32'hFFFF_F000) | (32'h100 + 32'($urandom_range(0, 63))),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom(),
            $urandom_range(0, 2));

    // LATENCY=1 with req_valid held high: stores then loads, in-order responses
    b_rsp_ready = 1'b1;
    for (int ph = 0; ph < 2; ph++) begin
      nacc = 0;
      b_req_valid = 1'b1; b_req_we = (ph == 0); b_req_size = 2'd2; b_req_unsigned = 0;
      for (int c = 0; c < 16; c++) begin
        chk("b_ready_alt", {31'h0, b_req_ready}, {31'h0, (c % 2 == 0)});
        chk("b_valid_alt", {31'h0, b_rsp_valid}, {31'h0, (c % 2 == 1)});
        if (b_rsp_valid) begin
          chk("b_q_nonempty", 32'(q_exp.size() > 0), 32'h1);
          if (q_exp.size() > 0) chk("b_rdata", b_rsp_rdata, q_exp.pop_front());
          chk("b_err", {31'h0, b_rsp_err}, 32'h0);
        end
        b_req_addr  = ($urandom() & 32'hFFFF_FFC0) | 32'(4 * nacc);
        b_req_wdata = $urandom();
        if (b_req_ready) begin
          if (ph == 0) begin
            wmem_b[nacc] = b_req_wdata;
            q_exp.push_back(32'h0);
          end else begin
            q_exp.push_back(wmem_b[nacc]);
          end
          nacc++;
        end
        @(posedge clk); #1;
      end
      b_req_valid = 1'b0;
      chk("b_drained", 32'(q_exp.size()), 32'h0);
      chk("b_accepts", 32'(nacc), 32'd8);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
